mat_vec_loader: RTL and testbench
=================================

Name: mat_vec_loader

Overview:
- Producer and consumer for the 8x8 matrix-vector MAC engine.
- Fetches the A matrix and B vector from memory over an Avalon-MM read master and serializes them into the engine's FIFO write ports.
- Starts the computation, waits for compute_done, then latches the eight 24-bit results for the host.
- Sits between the memory/host fabric and the engine, and owns the engine's reset and accumulator clear.

Parameters:
- ADDR_W, 32, width of mem_address and base_addr.
- WORD_STRIDE, 8, byte-address increment between consecutive 64-bit words.
- TIMEOUT_CYCLES, 4096, compute_done watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- go  input  1  single-cycle job request; ignored unless state is IDLE or DONE.
- base_addr  input  ADDR_W  byte address of word 0; sampled on an accepted go.
- busy  output  1  high from an accepted go until DONE.
- done  output  1  high in DONE; cleared by the next accepted go.
- mem_address  output  ADDR_W  read address.
- mem_read  output  1  read request.
- mem_readdata  input  64  read data.
- mem_readdatavalid  input  1  read data valid.
- mem_waitrequest  input  1  slave stall.
- eng_rst_n  output  1  engine reset, active low.
- clr_accum  output  1  engine accumulator clear.
- start_compute  output  1  engine start.
- fifo_a_data_0 .. fifo_a_data_7  output  8 each  A FIFO write data, one bus per FIFO.
- fifo_a_wren  output  8  A FIFO write enables; bit i drives FIFO i.
- fifo_a_full  input  8  A FIFO full flags.
- fifo_b_data  output  8  B FIFO write data.
- fifo_b_wren  output  1  B FIFO write enable.
- fifo_b_full  input  1  B FIFO full flag.
- all_fifos_full  input  1  engine status: every FIFO holds 8 entries.
- compute_done  input  1  engine status: computation finished.
- mac_out_0 .. mac_out_7  input  24 each  engine MAC results.
- result_0 .. result_7  output  24 each  latched results.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE. All outputs 0, except eng_rst_n=1. result_0..7 = 0.
- Memory layout:
  - Word k, k=0..7, at base_addr + k*WORD_STRIDE is row k of A. Byte 0 (bits 7:0) is A[k][0], byte 7 is A[k][7].
  - Word 8 is the B vector, with the same byte order.
- States and transitions:
  - IDLE/DONE: on go, capture base_addr, k=0, busy=1, done=0, go to ENG_RST.
  - ENG_RST: one cycle with eng_rst_n=0 and clr_accum=1, then go to REQ.
  - REQ: mem_read=1, mem_address = base + k*WORD_STRIDE. Address and read are held stable while mem_waitrequest=1. When mem_waitrequest=0, drop mem_read and go to WAIT_DATA.
  - WAIT_DATA: on mem_readdatavalid, capture the 64-bit word into the shift register, byte index j=0, go to WRITE. Only one read is outstanding at a time.
  - WRITE: each cycle, if the target FIFO is not full, drive byte j onto the target data bus, pulse its wren, and j++. The target is A FIFO k for k<8, else the B FIFO. If full, wren=0 and hold j (stall). After j=7 is written: if k<8, k++ and go to REQ; else go to START.
  - START: wait for all_fifos_full=1, then a one-cycle start_compute pulse, then WAIT_DONE.
  - WAIT_DONE: on compute_done=1, latch mac_out_i into result_i (same cycle), go to DONE.
  - DONE: done=1, busy=0.
- Every FIFO data bus holds its value when its wren=0; never more than one wren bit (including fifo_b_wren) is high in a cycle.
- Nominal latency with zero wait states and 1-cycle read latency: 9 words x (1 REQ + 1 WAIT_DATA + 8 WRITE) = 90 cycles, plus 1 for ENG_RST, plus START, plus engine time.
- go while busy: ignored.
- rst mid-job: immediate return to IDLE; mem_read and all wren drop in the same cycle. A read response arriving in IDLE is discarded.
- mem_readdatavalid arriving outside WAIT_DATA: ignored.
- result_i values persist until the next capture or rst.

Optional Feature:
- Macro: MAT_VEC_LOADER_TIMEOUT_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - A counter runs in START and WAIT_DONE. If it reaches TIMEOUT_CYCLES before the exit condition, go to DONE with err=1 and results not updated.
  - err clears on the next accepted go.
- Undefined: no err port, no counter; START and WAIT_DONE wait indefinitely.

Test Plan:
- Zero-wait memory; A[i][j]=i+1 for all j; B=all 1; base 0x100. Required: addresses 0x100..0x140 in steps of 8. fifo_a_wren[i] high exactly 8 cycles each, FIFOs written in order 0..7 then B. One start_compute pulse; with the engine model, result_i = 8*(i+1); done=1.
- mem_waitrequest held high 5 cycles on word 3 -> mem_address=0x118 and mem_read stable for all 5 cycles; exactly one read accepted per word.
- fifo_a_full[2] forced high 4 cycles mid-row 2 -> no wren during the stall; byte sequence in FIFO 2 continuous with no drop or duplicate.
- go pulsed during WRITE of word 4 -> ignored. A second go in DONE -> eng_rst_n low for exactly 1 cycle, clr_accum=1, new results latched.
- rst asserted in WAIT_DATA with a response arriving the next cycle -> all outputs at reset values; no wren; state IDLE.
- With MAT_VEC_LOADER_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, compute_done held 0 -> err=1 and done=1 after 16 cycles; result_i unchanged.

Source files
------------

// File: rtl/mat_vec_loader.sv
// mat_vec_loader: fetches A/B from memory, feeds the 8x8 MAC engine FIFOs, starts it and latches results.
// Optional watchdog on START/WAIT_DONE enabled by defining MAT_VEC_LOADER_TIMEOUT_EN (adds the err output).
module mat_vec_loader #(
  parameter int ADDR_W         = 32,
  parameter int WORD_STRIDE    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  output logic              eng_rst_n,
  output logic              clr_accum,
  output logic              start_compute,
  output logic [7:0]        fifo_a_data_0,
  output logic [7:0]        fifo_a_data_1,
  output logic [7:0]        fifo_a_data_2,
  output logic [7:0]        fifo_a_data_3,
  output logic [7:0]        fifo_a_data_4,
  output logic [7:0]        fifo_a_data_5,
  output logic [7:0]        fifo_a_data_6,
  output logic [7:0]        fifo_a_data_7,
  output logic [7:0]        fifo_a_wren,
  input  logic [7:0]        fifo_a_full,
  output logic [7:0]        fifo_b_data,
  output logic              fifo_b_wren,
  input  logic              fifo_b_full,
  input  logic              all_fifos_full,
  input  logic              compute_done,
  input  logic [23:0]       mac_out_0,
  input  logic [23:0]       mac_out_1,
  input  logic [23:0]       mac_out_2,
  input  logic [23:0]       mac_out_3,
  input  logic [23:0]       mac_out_4,
  input  logic [23:0]       mac_out_5,
  input  logic [23:0]       mac_out_6,
  input  logic [23:0]       mac_out_7,
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
  output logic              err,
`endif
  output logic [23:0]       result_0,
  output logic [23:0]       result_1,
  output logic [23:0]       result_2,
  output logic [23:0]       result_3,
  output logic [23:0]       result_4,
  output logic [23:0]       result_5,
  output logic [23:0]       result_6,
  output logic [23:0]       result_7
);
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ENG_RST   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_START     = 3'd5;
  localparam logic [2:0] S_WAIT_DONE = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        k_q, k_d;
  logic [2:0]        j_q, j_d;
  logic [63:0]       sr_q, sr_d;
  logic [7:0]        a_q [8];
  logic [7:0]        b_q;
  logic [23:0]       res_q [8];
  logic [23:0]       mac [8];
  logic [7:0]        a_dat [8];
  logic [7:0]        cur_byte;
  logic [7:0]        a_wr;
  logic              tgt_full, wr, accept, capture;
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, in_wait, tmo;
  assign err = err_q;
`endif
  assign mac = '{mac_out_0, mac_out_1, mac_out_2, mac_out_3, mac_out_4, mac_out_5, mac_out_6, mac_out_7};
  assign accept        = go && (state_q == S_IDLE || state_q == S_DONE);
  assign busy          = !(state_q == S_IDLE || state_q == S_DONE);
  assign done          = state_q == S_DONE;
  assign eng_rst_n     = state_q != S_ENG_RST;
  assign clr_accum     = state_q == S_ENG_RST;
  assign start_compute = state_q == S_START && all_fifos_full;
  assign mem_read      = state_q == S_REQ && !rst;
  assign mem_address   = state_q == S_REQ ? base_q + ADDR_W'(k_q) * ADDR_W'(WORD_STRIDE) : '0;
  assign cur_byte      = sr_q[{j_q, 3'b000} +: 8];
  assign tgt_full      = k_q[3] ? fifo_b_full : fifo_a_full[k_q[2:0]];
  assign wr            = state_q == S_WRITE && !tgt_full && !rst;
  assign a_wr          = (wr && !k_q[3]) ? 8'd1 << k_q[2:0] : 8'd0;
  assign fifo_a_wren   = a_wr;
  assign fifo_b_wren   = wr && k_q[3];
  assign fifo_b_data   = fifo_b_wren ? cur_byte : b_q;
  for (genvar i = 0; i < 8; i++) begin : g_a
    assign a_dat[i] = a_wr[i] ? cur_byte : a_q[i];
  end
  assign fifo_a_data_0 = a_dat[0];
  assign fifo_a_data_1 = a_dat[1];
  assign fifo_a_data_2 = a_dat[2];
  assign fifo_a_data_3 = a_dat[3];
  assign fifo_a_data_4 = a_dat[4];
  assign fifo_a_data_5 = a_dat[5];
  assign fifo_a_data_6 = a_dat[6];
  assign fifo_a_data_7 = a_dat[7];
  assign result_0 = res_q[0];
  assign result_1 = res_q[1];
  assign result_2 = res_q[2];
  assign result_3 = res_q[3];
  assign result_4 = res_q[4];
  assign result_5 = res_q[5];
  assign result_6 = res_q[6];
  assign result_7 = res_q[7];
  // Job sequencing: one read outstanding, eight byte writes per word, then start and wait for the engine.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    k_d     = k_q;
    j_d     = j_q;
    sr_d    = sr_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: if (go) begin
        state_d = S_ENG_RST;
        base_d  = base_addr;
        k_d     = 4'd0;
      end
      S_ENG_RST:   state_d = S_REQ;
      S_REQ:       if (!mem_waitrequest) state_d = S_WAIT_DATA;
      S_WAIT_DATA: if (mem_readdatavalid) begin
        sr_d    = mem_readdata;
        j_d     = 3'd0;
        state_d = S_WRITE;
      end
      S_WRITE: if (wr) begin
        j_d = j_q + 3'd1;
        if (j_q == 3'd7) begin
          k_d     = k_q[3] ? k_q : k_q + 4'd1;
          state_d = k_q[3] ? S_START : S_REQ;
        end
      end
      S_START:     if (all_fifos_full) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (compute_done) begin
        capture = 1'b1;
        state_d = S_DONE;
      end
      default:     state_d = S_IDLE;
    endcase
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
    in_wait = state_q == S_START || state_q == S_WAIT_DONE;
    tmo     = in_wait && state_d == state_q && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    cnt_d   = in_wait ? cnt_q + CW'(1) : '0;
    err_d   = accept ? 1'b0 : (tmo | err_q);
    if (tmo) state_d = S_DONE;
`endif
  end
  // State, held FIFO data buses and the result latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      k_q     <= '0;
      j_q     <= '0;
      sr_q    <= '0;
      b_q     <= '0;
      for (int n = 0; n < 8; n++) begin
        a_q[n]   <= '0;
        res_q[n] <= '0;
      end
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      k_q     <= k_d;
      j_q     <= j_d;
      sr_q    <= sr_d;
      if (fifo_b_wren) b_q <= cur_byte;
      for (int n = 0; n < 8; n++) begin
        if (a_wr[n]) a_q[n] <= cur_byte;
        if (capture) res_q[n] <= mac[n];
      end
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_mat_vec_loader.sv
// tb_mat_vec_loader: randomized jobs against a memory/engine model and a matrix-level reference.
module tb_mat_vec_loader;
  logic        clk = 0, rst = 1, go = 0;
  logic [31:0] base_addr = 0;
  logic        busy, done, mem_read, eng_rst_n, clr_accum, start_compute;
  logic [31:0] mem_address;
  logic [63:0] mem_readdata = 0;
  logic        mem_readdatavalid = 0, mem_waitrequest = 0;
  logic [7:0]  a_data [8];
  logic [7:0]  fifo_a_wren, fifo_a_full = 0, fifo_b_data;
  logic        fifo_b_wren, fifo_b_full = 0, all_fifos_full = 0, compute_done = 0;
  logic [23:0] mac [8];
  logic [23:0] res [8];
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
  logic        err;
`endif
  mat_vec_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .go(go), .base_addr(base_addr), .busy(busy), .done(done),
    .mem_address(mem_address), .mem_read(mem_read), .mem_readdata(mem_readdata),
    .mem_readdatavalid(mem_readdatavalid), .mem_waitrequest(mem_waitrequest),
    .eng_rst_n(eng_rst_n), .clr_accum(clr_accum), .start_compute(start_compute),
    .fifo_a_data_0(a_data[0]), .fifo_a_data_1(a_data[1]), .fifo_a_data_2(a_data[2]), .fifo_a_data_3(a_data[3]),
    .fifo_a_data_4(a_data[4]), .fifo_a_data_5(a_data[5]), .fifo_a_data_6(a_data[6]), .fifo_a_data_7(a_data[7]),
    .fifo_a_wren(fifo_a_wren), .fifo_a_full(fifo_a_full), .fifo_b_data(fifo_b_data),
    .fifo_b_wren(fifo_b_wren), .fifo_b_full(fifo_b_full), .all_fifos_full(all_fifos_full),
    .compute_done(compute_done),
    .mac_out_0(mac[0]), .mac_out_1(mac[1]), .mac_out_2(mac[2]), .mac_out_3(mac[3]),
    .mac_out_4(mac[4]), .mac_out_5(mac[5]), .mac_out_6(mac[6]), .mac_out_7(mac[7]),
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
    .err(err),
`endif
    .result_0(res[0]), .result_1(res[1]), .result_2(res[2]), .result_3(res[3]),
    .result_4(res[4]), .result_5(res[5]), .result_6(res[6]), .result_7(res[7])
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0]  A [8][8];
  logic [7:0]  B [8];
  logic [31:0] job_base, wait_addr;
  logic [7:0]  aq [9][$];
  logic [31:0] addr_log [$];
  int          wr_log [$];
  bit          pend, hold_rsp, rst_next, go_req, rnd_wait, rnd_stall, no_done, go_in_w4, forced, prev_forced;
  logic [63:0] pend_data;
  int          cyc, starts, eng_rst_cycles, clr_cycles, onehot_bad, full_bad;
  int          wait_left, stall_left, stall_fifo, stall_at, done_delay, start_cyc;
  function automatic logic [63:0] word_of(int k);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = (k < 8) ? A[k][j] : B[j];
    return w;
  endfunction
  task automatic step();
    int idx;
    @(negedge clk);
    cyc++;
    rst = rst_next;
    rst_next = 0;
    if (hold_rsp) begin
      mem_readdatavalid = 0;
      hold_rsp = 0;
    end else begin
      mem_readdatavalid = pend;
      mem_readdata = pend_data;
      pend = 0;
    end
    forced = 0;
    mem_waitrequest = 0;
    if (mem_read && wait_left > 0 && mem_address == wait_addr) begin
      mem_waitrequest = 1;
      forced = 1;
      wait_left--;
    end else if (mem_read && rnd_wait) mem_waitrequest = ($urandom_range(2) == 0);
    for (int i = 0; i < 8; i++) fifo_a_full[i] = aq[i].size() >= 8;
    fifo_b_full = aq[8].size() >= 8;
    if (stall_left > 0 && aq[stall_fifo].size() == stall_at) begin
      fifo_a_full[stall_fifo] = 1;
      stall_left--;
    end
    if (rnd_stall) begin
      for (int i = 0; i < 8; i++) fifo_a_full[i] |= ($urandom_range(3) == 0);
      fifo_b_full |= ($urandom_range(3) == 0);
    end
    all_fifos_full = 1;
    for (int i = 0; i < 9; i++) if (aq[i].size() != 8) all_fifos_full = 0;
    compute_done = 0;
    if (done_delay > 0) begin
      done_delay--;
      if (done_delay == 0) compute_done = 1;
    end
    go = go_req;
    if (go_req) base_addr = job_base;
    go_req = 0;
    if (go_in_w4 && wr_log.size() == 34) begin
      go = 1;
      base_addr = 32'hDEAD_0000;
      go_in_w4 = 0;
    end
    #1;
    if (prev_forced) check("wait_hold", {31'd0, mem_read, mem_address}, {31'd0, 1'b1, wait_addr});
    prev_forced = forced;
    if (!eng_rst_n) begin
      eng_rst_cycles++;
      for (int i = 0; i < 9; i++) aq[i].delete();
    end
    if (clr_accum) clr_cycles++;
    if ($countones({fifo_b_wren, fifo_a_wren}) > 1) onehot_bad++;
    if ((fifo_a_wren & fifo_a_full) != 0 || (fifo_b_wren && fifo_b_full)) full_bad++;
    for (int i = 0; i < 8; i++) if (fifo_a_wren[i]) begin
      aq[i].push_back(a_data[i]);
      wr_log.push_back(i);
    end
    if (fifo_b_wren) begin
      aq[8].push_back(fifo_b_data);
      wr_log.push_back(8);
    end
    if (mem_read && !mem_waitrequest) begin
      addr_log.push_back(mem_address);
      idx = int'((mem_address - job_base) >> 3);
      pend = 1;
      pend_data = (idx >= 0 && idx <= 8) ? word_of(idx) : 64'd0;
    end
    if (start_compute) begin
      starts++;
      start_cyc = cyc;
      for (int i = 0; i < 8; i++) begin
        int s = 0;
        for (int j = 0; j < 8; j++) if (j < aq[i].size() && j < aq[8].size()) s += aq[i][j] * aq[8][j];
        mac[i] = 24'(s);
      end
      if (!no_done) done_delay = 3;
    end
  endtask
  task automatic run_job(input logic [31:0] base, input bit timeout);
    logic [23:0] old [8];
    logic [23:0] exp_res [8];
    logic [63:0] w;
    int t = 0, bad = 0;
    job_base = base;
    addr_log.delete();
    wr_log.delete();
    starts = 0;
    eng_rst_cycles = 0;
    clr_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      int s = 0;
      for (int j = 0; j < 8; j++) s += A[i][j] * B[j];
      exp_res[i] = 24'(s);
      old[i] = res[i];
    end
    go_req = 1;
    step();
    do begin
      step();
      t++;
    end while (!done && t < 3000);
    check("job_done", {63'd0, done}, 64'd1);
    check("job_busy", {63'd0, busy}, 64'd0);
    check("addr_count", addr_log.size(), 9);
    for (int k = 0; k < 9 && k < addr_log.size(); k++)
      check($sformatf("addr%0d", k), addr_log[k], base + 32'(8 * k));
    for (int n = 0; n < wr_log.size(); n++) if (wr_log[n] != n / 8) bad++;
    check("wr_count", wr_log.size(), 72);
    check("wr_order", bad, 0);
    for (int i = 0; i < 9; i++) begin
      w = 0;
      for (int j = 0; j < 8 && j < aq[i].size(); j++) w[8*j +: 8] = aq[i][j];
      check($sformatf("fifo%0d", i), w, word_of(i));
    end
    check("starts", starts, 1);
    check("eng_rst_cycles", eng_rst_cycles, 1);
    check("clr_cycles", clr_cycles, 1);
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
    check("err", {63'd0, err}, {63'd0, timeout});
    if (timeout) check("timeout_len", cyc - start_cyc, 16);
`endif
    for (int i = 0; i < 8; i++) check($sformatf("result%0d", i), res[i], timeout ? old[i] : exp_res[i]);
  endtask
  task automatic rand_data();
    for (int i = 0; i < 8; i++) begin
      B[i] = 8'($urandom);
      for (int j = 0; j < 8; j++) A[i][j] = 8'($urandom);
    end
  endtask
  initial begin
    int t;
    for (int i = 0; i < 8; i++) mac[i] = 0;
    repeat (3) begin
      rst_next = 1;
      step();
    end
    step();
    check("rst_busy", {63'd0, busy}, 0);
    check("rst_done", {63'd0, done}, 0);
    check("rst_eng_rst_n", {63'd0, eng_rst_n}, 1);
    check("rst_ctl", {61'd0, mem_read, clr_accum, start_compute}, 0);
    check("rst_wren", {55'd0, fifo_b_wren, fifo_a_wren}, 0);
    check("rst_addr", mem_address, 0);
    check("rst_result0", res[0], 0);
    for (int i = 0; i < 8; i++) begin
      B[i] = 8'd1;
      for (int j = 0; j < 8; j++) A[i][j] = 8'(i + 1);
    end
    run_job(32'h100, 0);
    rand_data();
    wait_addr = 32'h118;
    wait_left = 5;
    run_job(32'h100, 0);
    check("wait_used", wait_left, 0);
    rand_data();
    stall_fifo = 2;
    stall_at = 3;
    stall_left = 4;
    run_job(32'h4000, 0);
    check("stall_used", stall_left, 0);
    rand_data();
    go_in_w4 = 1;
    run_job(32'h8000_0040, 0);
    check("go_w4_fired", {63'd0, go_in_w4}, 0);
    rnd_wait = 1;
    rnd_stall = 1;
    repeat (3) begin
      rand_data();
      run_job($urandom & 32'hFFFF_FFF8, 0);
    end
    rnd_wait = 0;
    rnd_stall = 0;
    rand_data();
    job_base = 32'h2000;
    addr_log.delete();
    go_req = 1;
    t = 0;
    do begin
      step();
      t++;
    end while (!(addr_log.size() == 3 && pend) && t < 500);
    check("rst_mid_reached", addr_log.size(), 3);
    rst_next = 1;
    hold_rsp = 1;
    step();
    step();
    check("mid_rst_valid_seen", {63'd0, mem_readdatavalid}, 1);
    repeat (2) begin
      check("mid_rst_busy", {62'd0, busy, done}, 0);
      check("mid_rst_ctl", {60'd0, mem_read, clr_accum, start_compute, eng_rst_n}, 1);
      check("mid_rst_wren", {55'd0, fifo_b_wren, fifo_a_wren}, 0);
      check("mid_rst_result", res[3], 0);
      step();
    end
    run_job(32'h2000, 0);
`ifdef MAT_VEC_LOADER_TIMEOUT_EN
    rand_data();
    no_done = 1;
    run_job(32'h3000, 1);
    no_done = 0;
    rand_data();
    run_job(32'h3000, 0);
`endif
    check("onehot_violations", onehot_bad, 0);
    check("write_while_full", full_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
